redux_prog_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the Redux-V core's instruction memory. Accepts a length-prefixed byte stream over a valid/ready handshake, writes each program byte into instruction memory at consecutive addresses, and holds the core in reset until the image is complete. On completion it releases the core; on a malformed stream it parks in a sticky error state.

---
 rtl/redux_loader_pkg.sv | 18 +
 rtl/loader_sum8.sv | 27 ++
 rtl/redux_prog_loader.sv | 151 +++++++++++++++
 tb/tb_redux_prog_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/redux_loader_pkg.sv
// Shared types and constants for the Redux-V boot program loader.
// Optional checksum support is selected with REDUX_LOADER_CHECKSUM_EN.
package redux_loader_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [BYTE_W-1:0] LEN_ZERO = 8'h00;

   typedef enum logic [2:0] {
      LEN,
      DATA,
      CSUM,
      DRAIN,
      RUN,
      ERR
   } state_e;

endpackage : redux_loader_pkg

// File: rtl/loader_sum8.sv
// 8-bit running-sum accumulator with synchronous clear and enable.
// Used only when REDUX_LOADER_CHECKSUM_EN is defined.
module loader_sum8
   import redux_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [BYTE_W-1:0] data_i,
   output logic [BYTE_W-1:0] sum_o
);

   logic [BYTE_W-1:0] sum_q;

   // Carry out of bit 7 is discarded: the sum is mod 256.
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         sum_q <= '0;
      end else if (en_i) begin
         sum_q <= sum_q + data_i;
      end
   end

   assign sum_o = sum_q;

endmodule : loader_sum8

// File: rtl/redux_prog_loader.sv
// Length-prefixed byte-stream loader into instruction memory; holds the core in reset until the image lands.
// Define REDUX_LOADER_CHECKSUM_EN to require and verify a trailing 8-bit sum byte.
module redux_prog_loader
   import redux_loader_pkg::*;
#(
   parameter logic [BYTE_W-1:0] BASE_ADDR = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [BYTE_W-1:0] mem_addr,
   output logic [BYTE_W-1:0] mem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              error
);

   state_e            state_q, state_d;
   logic [BYTE_W-1:0] len_q, len_d;
   logic [BYTE_W-1:0] count_q, count_d;
   logic              we_q, we_d;
   logic [BYTE_W-1:0] addr_q, addr_d;
   logic [BYTE_W-1:0] wdata_q, wdata_d;
   logic              ready_q, ready_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              accept_c;

`ifdef REDUX_LOADER_CHECKSUM_EN
   logic              sum_clr_c;
   logic              sum_en_c;
   logic [BYTE_W-1:0] sum_c;

   loader_sum8 u_sum (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (sum_clr_c),
      .en_i   (sum_en_c),
      .data_i (in_data),
      .sum_o  (sum_c)
   );
`endif

   // in_ready is a registered decode of the state, so it never depends on in_valid.
   assign accept_c = in_valid && ready_q;

   // Next-state, counter and write-register logic.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      count_d = count_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef REDUX_LOADER_CHECKSUM_EN
      sum_clr_c = 1'b0;
      sum_en_c  = 1'b0;
`endif

      case (state_q)
         LEN: begin
            if (accept_c) begin
               if (in_data == LEN_ZERO) begin
                  state_d = ERR;
               end else begin
                  len_d   = in_data;
                  count_d = '0;
                  state_d = DATA;
`ifdef REDUX_LOADER_CHECKSUM_EN
                  sum_clr_c = 1'b1;
`endif
               end
            end
         end
         DATA: begin
            if (accept_c) begin
               we_d    = 1'b1;
               addr_d  = BASE_ADDR + count_q;
               wdata_d = in_data;
               count_d = count_q + 8'd1;
`ifdef REDUX_LOADER_CHECKSUM_EN
               sum_en_c = 1'b1;
`endif
               if (count_q == (len_q - 8'd1)) begin
`ifdef REDUX_LOADER_CHECKSUM_EN
                  state_d = CSUM;
`else
                  state_d = DRAIN;
`endif
               end
            end
         end
`ifdef REDUX_LOADER_CHECKSUM_EN
         CSUM: begin
            if (accept_c) begin
               state_d = (in_data == sum_c) ? DRAIN : ERR;
            end
         end
`endif
         DRAIN:   state_d = RUN;
         RUN:     state_d = RUN;
         ERR:     state_d = ERR;
         default: state_d = ERR;
      endcase

      ready_d   = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
      cpu_rst_d = (state_d != RUN);
      done_d    = (state_d == RUN);
      error_d   = (state_d == ERR);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= LEN;
         len_q     <= '0;
         count_q   <= '0;
         we_q      <= 1'b0;
         addr_q    <= BASE_ADDR;
         wdata_q   <= '0;
         ready_q   <= 1'b1;
         cpu_rst_q <= 1'b1;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         count_q   <= count_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ready_q   <= ready_d;
         cpu_rst_q <= cpu_rst_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign in_ready  = ready_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_rst   = cpu_rst_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule : redux_prog_loader

// File: tb/tb_redux_prog_loader.sv
// Scoreboard bench for redux_prog_loader: two instances (base 00 and base F0).
// Works with or without REDUX_LOADER_CHECKSUM_EN defined.
module tb_redux_prog_loader;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst       [2];
   logic       in_valid  [2];
   logic [7:0] in_data   [2];
   logic       in_ready  [2];
   logic       mem_we    [2];
   logic [7:0] mem_addr  [2];
   logic [7:0] mem_wdata [2];
   logic       cpu_rst   [2];
   logic       done      [2];
   logic       error     [2];

   redux_prog_loader #(.BASE_ADDR(8'h00)) u_dut0 (
      .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
      .in_ready(in_ready[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .cpu_rst(cpu_rst[0]), .done(done[0]), .error(error[0])
   );

   redux_prog_loader #(.BASE_ADDR(8'hF0)) u_dut1 (
      .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
      .in_ready(in_ready[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .cpu_rst(cpu_rst[1]), .done(done[1]), .error(error[1])
   );

   int          n_checks = 0;
   int          n_err    = 0;
   logic [15:0] exp_q0[$];
   logic [15:0] exp_q1[$];
   int          wcnt [2];
   logic [7:0]  last_addr [2];
   logic [7:0]  stim[$];
   int          gaps[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_exp(input int k, input logic [7:0] a, input logic [7:0] d);
      if (k == 0) exp_q0.push_back({a, d});
      else        exp_q1.push_back({a, d});
   endtask

   // Every write strobe must match the oldest expected {addr, data}.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (mem_we[k] === 1'b1) begin
            logic        have;
            logic [15:0] e;
            have = (k == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
            chk("we_expected", 32'(have), 32'd1);
            if (have) begin
               e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
               chk("wr_addr", 32'(mem_addr[k]), 32'(e[15:8]));
               chk("wr_data", 32'(mem_wdata[k]), 32'(e[7:0]));
            end
            wcnt[k]++;
            last_addr[k] = mem_addr[k];
         end
      end
   end

   task automatic chk_st(input int k, input string p, input logic r, input logic d,
                         input logic e, input logic c);
      chk({p, ".in_ready"}, 32'(in_ready[k]), 32'(r));
      chk({p, ".done"},     32'(done[k]),     32'(d));
      chk({p, ".error"},    32'(error[k]),    32'(e));
      chk({p, ".cpu_rst"},  32'(cpu_rst[k]),  32'(c));
   endtask

   task automatic reset_dut(input int k);
      rst[k]      = 1'b1;
      in_valid[k] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst[k] = 1'b0;
   endtask

   // Offers one byte after `gap` idle cycles; returns at accepting edge + 1.
   task automatic drive_byte(input int k, input logic [7:0] b, input int gap);
      logic ok;
      ok = 1'b0;
      for (int g = 0; g < gap; g++) begin
         in_valid[k] = 1'b0;
         @(posedge clk);
         #1;
      end
      in_valid[k] = 1'b1;
      in_data[k]  = b;
      for (int c = 0; c < 20 && !ok; c++) begin
         if (in_ready[k] === 1'b1) ok = 1'b1;
         @(posedge clk);
      end
      #1;
      in_valid[k] = 1'b0;
      chk("accept", 32'(ok), 32'd1);
   endtask

   task automatic send_stream(input int k, input logic [7:0] base);
      int n;
      n = int'(stim[0]);
      for (int i = 0; i < stim.size(); i++) begin
         drive_byte(k, stim[i], (i < gaps.size()) ? gaps[i] : 0);
         if (i >= 1 && i <= n) push_exp(k, base + 8'(i - 1), stim[i]);
      end
   endtask

   task automatic add_csum();
`ifdef REDUX_LOADER_CHECKSUM_EN
      logic [7:0] s;
      s = 8'h00;
      for (int i = 1; i < stim.size(); i++) s = s + stim[i];
      stim.push_back(s);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; in_valid[k] = 1'b0; in_data[k] = 8'h00; wcnt[k] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst[0] = 1'b0; rst[1] = 1'b0;

      // Reset values
      chk_st(0, "rst0", 1'b1, 1'b0, 1'b0, 1'b1);
      chk("rst0.mem_we",    32'(mem_we[0]),    32'd0);
      chk("rst0.mem_addr",  32'(mem_addr[0]),  32'h00);
      chk("rst0.mem_wdata", 32'(mem_wdata[0]), 32'h00);
      chk("rst1.mem_addr",  32'(mem_addr[1]),  32'hF0);

      // Nominal load, in_valid held high
      stim = {8'h03, 8'h1A, 8'h2B, 8'h3C};
      add_csum();
`ifdef REDUX_LOADER_CHECKSUM_EN
      chk("nom.csum_byte", 32'(stim[4]), 32'h81);
`endif
      gaps = {};
      send_stream(0, 8'h00);
      chk_st(0, "nom.drain", 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      chk_st(0, "nom.run", 1'b0, 1'b1, 1'b0, 1'b0);
      chk("nom.wcnt", 32'(wcnt[0]), 32'd3);
      w0 = wcnt[0];
      in_valid[0] = 1'b1; in_data[0] = 8'h55;
      repeat (3) @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      chk("run.ignore_wcnt", 32'(wcnt[0]), 32'(w0));
      chk_st(0, "run.hold", 1'b0, 1'b1, 1'b0, 1'b0);

      // Bad checksum (or plain short load when checksum is disabled)
      reset_dut(0);
      w0 = wcnt[0];
`ifdef REDUX_LOADER_CHECKSUM_EN
      stim = {8'h02, 8'h10, 8'h20, 8'h31};
      send_stream(0, 8'h00);
      chk_st(0, "badcs.err", 1'b0, 1'b0, 1'b1, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      chk_st(0, "badcs.hold", 1'b0, 1'b0, 1'b1, 1'b1);
`else
      stim = {8'h02, 8'h10, 8'h20};
      send_stream(0, 8'h00);
      @(posedge clk); #1;
      chk_st(0, "short.run", 1'b0, 1'b1, 1'b0, 1'b0);
`endif
      chk("badcs.wcnt", 32'(wcnt[0] - w0), 32'd2);

      // Zero length goes straight to ERR with no writes
      reset_dut(0);
      w0 = wcnt[0];
      stim = {8'h00};
      send_stream(0, 8'h00);
      chk_st(0, "zlen.err", 1'b0, 1'b0, 1'b1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("zlen.wcnt", 32'(wcnt[0] - w0), 32'd0);

      // Gapped handshake: valid 1,0,0,1,0,1
      reset_dut(0);
      w0 = wcnt[0];
      stim = {8'h02, 8'hAA, 8'hBB};
      add_csum();
      gaps = {0, 2, 1, 0};
      send_stream(0, 8'h00);
      gaps = {};
      @(posedge clk); #1;
      chk_st(0, "gap.run", 1'b0, 1'b1, 1'b0, 1'b0);
      chk("gap.wcnt", 32'(wcnt[0] - w0), 32'd2);
      chk("gap.last_addr", 32'(last_addr[0]), 32'h01);

      // Address wrap on the F0-based instance
      stim = {8'd20};
      for (int i = 0; i < 20; i++) stim.push_back(8'(i * 7 + 3));
      add_csum();
      send_stream(1, 8'hF0);
      @(posedge clk); #1;
      chk_st(1, "wrap.run", 1'b0, 1'b1, 1'b0, 1'b0);
      chk("wrap.wcnt", 32'(wcnt[1]), 32'd20);
      chk("wrap.last_addr", 32'(last_addr[1]), 32'h03);

      // Reset after the 2nd of 5 data bytes, while the 3rd is offered
      reset_dut(0);
      w0 = wcnt[0];
      drive_byte(0, 8'h05, 0);
      drive_byte(0, 8'hD0, 0);
      push_exp(0, 8'h00, 8'hD0);
      drive_byte(0, 8'hD1, 0);
      push_exp(0, 8'h01, 8'hD1);
      rst[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 8'hD2;
      @(posedge clk); #1;
      rst[0] = 1'b0; in_valid[0] = 1'b0;
      chk("abort.mem_we", 32'(mem_we[0]), 32'd0);
      chk_st(0, "abort.len", 1'b1, 1'b0, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("abort.wcnt", 32'(wcnt[0] - w0), 32'd2);
      stim = {8'h01, 8'h77};
      add_csum();
      send_stream(0, 8'h00);
      @(posedge clk); #1;
      chk_st(0, "reload.run", 1'b0, 1'b1, 1'b0, 1'b0);
      chk("reload.last_addr", 32'(last_addr[0]), 32'h00);
      chk("reload.wcnt", 32'(wcnt[0] - w0), 32'd3);

      repeat (2) @(posedge clk);
      #1;
      chk("q0_empty", 32'(exp_q0.size()), 32'd0);
      chk("q1_empty", 32'(exp_q1.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule : tb_redux_prog_loader
